// File: rtl/mbist_march_ctrl_if.sv
// Memory-side bus between the March C- controller (master) and the SRAM under test (slave).
interface mbist_march_ctrl_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
);
  logic                  write_read;
  logic [ADDR_WIDTH-1:0] address;
  logic [DATA_WIDTH-1:0] wdata;
  logic [DATA_WIDTH-1:0] rdata;

  modport master (output write_read, output address, output wdata, input rdata);
  modport slave  (input write_read, input address, input wdata, output rdata);
endinterface

// File: rtl/mbist_march_ctrl.sv
// March C- MBIST initiator: sequences E0..E5 over the SRAM, compares reads against the
// expected background and captures diagnostics for the first miscompare of each run.
//
// state | meaning
// IDLE  | waiting for start; memory port parked (read, address 0, wdata 0)
// SETUP | one cycle per element; start address and element write value are presented
// RD    | read issued at the current address
// RW1   | read pipeline wait
// CMP   | rdata valid; compare against the expected background
// WR    | write the element value to the current address
// DONE  | busy already low; done pulse, then IDLE
module mbist_march_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int DEPTH      = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  mbist_march_ctrl_if.master     mem,
  output logic                   busy,
  output logic                   done,
  output logic                   fail,
  output logic [2:0]             fail_elem,
  output logic [ADDR_WIDTH-1:0]  fail_addr,
  output logic [DATA_WIDTH-1:0]  fail_syn,
  output logic [15:0]            fail_count
);
  typedef enum logic [2:0] {IDLE, SETUP, RD, RW1, CMP, WR, DONE} state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [DATA_WIDTH-1:0] ONES      = '1;
  localparam logic [DATA_WIDTH-1:0] ZEROS     = '0;
  localparam logic [2:0]            LAST_ELEM = 3'd5;

  state_t                state;
  logic [2:0]            elem;
  logic                  wr_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;

  logic                  elem_down;
  logic                  at_last;
  logic [DATA_WIDTH-1:0] exp_word;
  logic [2:0]            nxt_elem;
  logic                  nxt_down;
  logic [DATA_WIDTH-1:0] nxt_wval;
  logic [ADDR_WIDTH-1:0] step_addr;
  logic                  miscmp;
  logic                  advance;

  assign mem.write_read = wr_q;
  assign mem.address    = addr_q;
  assign mem.wdata      = wdata_q;

  always_comb begin
    elem_down = (elem == 3'd3) || (elem == 3'd4);
    at_last   = elem_down ? (addr_q == '0) : (addr_q == LAST_ADDR);
    exp_word  = ((elem == 3'd2) || (elem == 3'd4)) ? ONES : ZEROS;
    nxt_elem  = elem + 3'd1;
    nxt_down  = (nxt_elem == 3'd3) || (nxt_elem == 3'd4);
    nxt_wval  = ((nxt_elem == 3'd1) || (nxt_elem == 3'd3)) ? ONES : ZEROS;
    step_addr = elem_down ? (addr_q - ADDR_WIDTH'(1)) : (addr_q + ADDR_WIDTH'(1));
    miscmp    = (mem.rdata != exp_word);
    // E5 has no write, so its address step happens straight out of CMP
    advance   = (state == WR) || ((state == CMP) && (elem == LAST_ELEM));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      elem       <= '0;
      wr_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      fail       <= 1'b0;
      fail_elem  <= '0;
      fail_addr  <= '0;
      fail_syn   <= '0;
      fail_count <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            fail       <= 1'b0;
            fail_elem  <= '0;
            fail_addr  <= '0;
            fail_syn   <= '0;
            fail_count <= '0;
            busy       <= 1'b1;
            elem       <= '0;
            addr_q     <= '0;
            wdata_q    <= ZEROS;
            wr_q       <= 1'b0;
            state      <= SETUP;
          end
        end
        SETUP: begin
          if (elem == 3'd0) begin
            wr_q  <= 1'b1;
            state <= WR;
          end else begin
            state <= RD;
          end
        end
        RD:  state <= RW1;
        RW1: state <= CMP;
        CMP: begin
          if (miscmp) begin
            fail <= 1'b1;
            if (fail_count != 16'hFFFF) fail_count <= fail_count + 16'd1;
            if (!fail) begin
              fail_elem <= elem;
              fail_addr <= addr_q;
              fail_syn  <= mem.rdata ^ exp_word;
            end
          end
          if (elem != LAST_ELEM) begin
            wr_q  <= 1'b1;
            state <= WR;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase

      if (advance) begin
        if (at_last) begin
          wr_q <= 1'b0;
          if (elem == LAST_ELEM) begin
            busy    <= 1'b0;
            done    <= 1'b1;
            addr_q  <= '0;
            wdata_q <= '0;
            state   <= DONE;
          end else begin
            elem    <= nxt_elem;
            addr_q  <= nxt_down ? LAST_ADDR : '0;
            wdata_q <= nxt_wval;
            state   <= SETUP;
          end
        end else begin
          addr_q <= step_addr;
          wr_q   <= (elem == 3'd0);
          state  <= (elem == 3'd0) ? WR : RD;
        end
      end
    end
  end
endmodule
